slave_ram_loader_ctrl: RTL and testbench
========================================

Name: slave_ram_loader_ctrl

Overview:
- Synthesizable front-end harness that sits directly upstream of the HLS-generated `main` accelerator.
- Accepts host commands over a valid/ready stream and acts on them through the accelerator's slave RAM port:
  - writes bytes into the accelerator's internal memory;
  - reads bytes back out;
  - launches a run, counts cycles until `done_port`, and returns the count.
- Replaces the file-driven preload/start/cycle-count logic with hardware usable on FPGA.

Parameters:
- N_CH, 2: slave RAM channels on the accelerator. Only channel 0 is driven; all other channel slices are driven 0.
- ADDR_W, 7: per-channel slave address width.
- DATA_W, 8: per-channel slave data width.
- SIZE_W, 4: per-channel `data_ram_size` width.
- CNT_W, 32: cycle counter width.
- RUN_TIMEOUT, 200000000: maximum run cycles before abort.
- MEM_TIMEOUT, 16: maximum cycles to wait for `Sout_DataRdy[0]`.

Ports:
- clock, in, 1: single clock; all logic on posedge.
- reset, in, 1: synchronous, active-low reset.
- cmd_valid, in, 1: command valid.
- cmd_ready, out, 1: command accepted when valid && ready.
- cmd_op, in, 2: command opcode. 00 = write, 01 = read, 10 = run, 11 = illegal.
- cmd_addr, in, ADDR_W: slave byte address.
- cmd_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: response valid. Held until rsp_ready.
- rsp_ready, in, 1: response consumed.
- rsp_status, out, 2: 0 = ok, 1 = timeout, 2 = illegal op.
- rsp_data, out, CNT_W: read data (zero-extended) or cycle count; 0 for write/illegal.
- start_port, out, 1: accelerator start pulse.
- done_port, in, 1: accelerator done.
- S_oe_ram, out, N_CH: read enable per channel.
- S_we_ram, out, N_CH: write enable per channel.
- S_addr_ram, out, N_CH*ADDR_W: address bus.
- S_Wdata_ram, out, N_CH*DATA_W: write data bus.
- S_data_ram_size, out, N_CH*SIZE_W: access size in bits.
- Sout_Rdata_ram, in, N_CH*DATA_W: read data bus.
- Sout_DataRdy, in, N_CH: access complete, per channel.

Behaviour:
- **Reset** (reset==0 at posedge):
  - state=IDLE;
  - all outputs 0, including cmd_ready, rsp_*, start_port and all S_* buses;
  - counters cleared.
  - Reset mid-operation abandons the command; no response is produced.
- **States:** IDLE, WR, RD, START, RUN, RSP.
- **IDLE:**
  - cmd_ready=1; this is the only state with cmd_ready=1. One command is in flight at a time.
  - On accept, cmd_addr and cmd_wdata are latched.
  - op 00 -> WR, op 01 -> RD, op 10 -> START.
  - op 11 -> RSP with status 2 and data 0, with no bus activity.
- **WR** (entered the cycle after accept):
  - Drives S_we_ram[0]=1, channel-0 address, wdata, and size=DATA_W, held constant every cycle.
  - On the first posedge with Sout_DataRdy[0]==1: go to RSP with status 0; the enable drops the next cycle.
  - Wait counter increments each WR cycle. If MEM_TIMEOUT cycles pass without DataRdy: go to RSP with status 1.
- **RD:**
  - Same rules as WR, but drives S_oe_ram[0]=1 instead of the write enable.
  - On DataRdy, captures Sout_Rdata_ram[DATA_W-1:0] into rsp_data, zero-extended.
- **START:**
  - start_port=1 for exactly one cycle; cycle counter cnt=1 in this cycle.
  - Next state RUN.
  - If done_port==1 in START: go to RSP with rsp_data=1.
- **RUN:**
  - cnt increments every cycle.
  - Posedge with done_port==1: RSP, status 0, rsp_data = cnt value of that cycle. The count includes both the start cycle and the done cycle.
  - If cnt reaches RUN_TIMEOUT without done: RSP, status 1, rsp_data=RUN_TIMEOUT.
  - The accelerator state after a timeout is undefined; the host must reset.
- **RSP:**
  - rsp_valid=1 with stable status/data until rsp_ready is sampled 1; then IDLE.
  - Exactly one response per accepted command.
  - A new command can be accepted no earlier than the cycle after the handshake.
- **Counter width:** saturates at all-ones and never wraps.
- **Bus drive:** S_oe_ram and S_we_ram are never both high.
- **Channel 1 and above:** driven 0 at all times. Their Sout_DataRdy and Sout_Rdata_ram inputs are ignored.

Test Plan:
- Reset held low 3 cycles with cmd_valid=1 -> no accept; all outputs 0; first cycle after release, cmd_ready=1.
- Write addr=0x05, data=0xA7; slave asserts DataRdy 2 cycles after we -> S_we_ram=01, S_addr_ram[6:0]=5, S_Wdata_ram[7:0]=A7, size slice=8 for exactly 2 cycles; then rsp status 0, data 0.
- Read addr=0x05 returning 0xA7 after 2 cycles -> rsp_data=0x000000A7, status 0; S_oe_ram high 2 cycles; S_we_ram stays 0.
- Run command; done_port pulses high 10 cycles after the start_port cycle -> start_port high exactly 1 cycle; rsp_data=11, status 0.
- Run with RUN_TIMEOUT=50 and done never asserted -> rsp status 1, data 50. Read with DataRdy never asserted -> status 1 after 16 cycles.
- op=11 -> status 2 with no S_* activity. Also: rsp_ready held low 5 cycles -> rsp stable, cmd_ready 0; reset pulsed mid-RUN -> no response, start_port 0, IDLE.

Source files
------------

// File: rtl/slave_ram_loader_ctrl.sv
// Host-command front end for the HLS accelerator: byte writes/reads over slave RAM
// channel 0 and start/done run timing, with one command in flight at a time.
module slave_ram_loader_ctrl #(
    parameter int N_CH        = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SIZE_W      = 4,
    parameter int CNT_W       = 32,
    parameter int RUN_TIMEOUT = 200000000,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_status,
    output logic [CNT_W-1:0]         rsp_data,
    output logic                     start_port,
    input  logic                     done_port,
    output logic [N_CH-1:0]          S_oe_ram,
    output logic [N_CH-1:0]          S_we_ram,
    output logic [N_CH*ADDR_W-1:0]   S_addr_ram,
    output logic [N_CH*DATA_W-1:0]   S_Wdata_ram,
    output logic [N_CH*SIZE_W-1:0]   S_data_ram_size,
    input  logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [N_CH-1:0]          Sout_DataRdy
);

    localparam int AW_ALL = N_CH * ADDR_W;
    localparam int DW_ALL = N_CH * DATA_W;
    localparam int SW_ALL = N_CH * SIZE_W;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] MEM_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  RUN_TO    = CNT_W'(RUN_TIMEOUT);
    localparam logic [SIZE_W-1:0] SIZE_BITS = SIZE_W'(DATA_W);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ILLEGAL = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_START, S_RUN, S_RSP} state_t;

    state_t             state_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic [1:0]         rsp_status_q;
    logic [CNT_W-1:0]   rsp_data_q;
    logic               start_q;
    logic               oe_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [SIZE_W-1:0]  size_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WAIT_W-1:0]  wait_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               unused_slave_in;

    assign wait_d = wait_q + 1'b1;
    assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Only channel 0 is ever driven; the other channels' returns are ignored.
    assign unused_slave_in = ^{Sout_DataRdy, Sout_Rdata_ram};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_data_q   <= '0;
            start_q      <= 1'b0;
            oe_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            wait_q       <= '0;
            cnt_q        <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        wait_q      <= '0;
                        case (cmd_op)
                            2'b00: begin
                                state_q <= S_WR;
                                we_q    <= 1'b1;
                                addr_q  <= cmd_addr;
                                wdata_q <= cmd_wdata;
                                size_q  <= SIZE_BITS;
                            end
                            2'b01: begin
                                state_q <= S_RD;
                                oe_q    <= 1'b1;
                                addr_q  <= cmd_addr;
                                size_q  <= SIZE_BITS;
                            end
                            2'b10: begin
                                state_q <= S_START;
                                start_q <= 1'b1;
                                cnt_q   <= CNT_W'(1);
                            end
                            default: begin
                                state_q      <= S_RSP;
                                rsp_valid_q  <= 1'b1;
                                rsp_status_q <= ST_ILLEGAL;
                                rsp_data_q   <= '0;
                            end
                        endcase
                    end
                end
                S_WR, S_RD: begin
                    // A late DataRdy on the final wait cycle still counts as success.
                    if (Sout_DataRdy[0] || wait_q == MEM_LAST) begin
                        state_q      <= S_RSP;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= Sout_DataRdy[0] ? ST_OK : ST_TIMEOUT;
                        rsp_data_q   <= (Sout_DataRdy[0] && state_q == S_RD)
                                        ? CNT_W'(Sout_Rdata_ram[DATA_W-1:0]) : '0;
                        oe_q         <= 1'b0;
                        we_q         <= 1'b0;
                        addr_q       <= '0;
                        wdata_q      <= '0;
                        size_q       <= '0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_START, S_RUN: begin
                    if (done_port) begin
                        state_q      <= S_RSP;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_OK;
                        rsp_data_q   <= cnt_q;
                    end else if (cnt_q >= RUN_TO) begin
                        state_q      <= S_RSP;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_TIMEOUT;
                        rsp_data_q   <= RUN_TO;
                    end else begin
                        state_q <= S_RUN;
                        cnt_q   <= cnt_d;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        state_q      <= S_IDLE;
                        cmd_ready_q  <= 1'b1;
                        rsp_valid_q  <= 1'b0;
                        rsp_status_q <= ST_OK;
                        rsp_data_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_status      = rsp_status_q;
    assign rsp_data        = rsp_data_q;
    assign start_port      = start_q;
    assign S_oe_ram        = N_CH'(oe_q);
    assign S_we_ram        = N_CH'(we_q);
    assign S_addr_ram      = AW_ALL'(addr_q);
    assign S_Wdata_ram     = DW_ALL'(wdata_q);
    assign S_data_ram_size = SW_ALL'(size_q);

endmodule

// File: tb/tb_slave_ram_loader_ctrl.sv
// Bench for slave_ram_loader_ctrl: directed and random commands against an
// emulated slave RAM / accelerator and a command-level reference model.
module tb_slave_ram_loader_ctrl;

    localparam int RUN_TO = 50;
    localparam int MEM_TO = 16;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;
    logic        start_port;
    logic        done_port;
    logic [1:0]  S_oe_ram;
    logic [1:0]  S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;

    logic [7:0] model_mem [128];
    logic [7:0] slave_mem [128];

    int n_checks = 0;
    int n_pass   = 0;

    logic [78:0] all_outs;
    assign all_outs = {cmd_ready, rsp_valid, rsp_status, rsp_data, start_port, S_oe_ram,
                       S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size};

    slave_ram_loader_ctrl #(
        .N_CH(2), .ADDR_W(7), .DATA_W(8), .SIZE_W(4), .CNT_W(32),
        .RUN_TIMEOUT(RUN_TO), .MEM_TIMEOUT(MEM_TO)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_data(rsp_data),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // lat: for write/read, enable cycles before the slave answers (0 or >MEM_TO: never in time);
    //      for run, cycles after the start cycle at which done pulses (-1: never).
    task automatic run_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [7:0] wd,
                           input int lat, input int hold, input string tag);
        logic [1:0]  e_st;
        logic [31:0] e_d;
        int          e_we, e_oe, e_starts;
        int          we_cnt, oe_cnt, starts, age, cyc;
        bit          running, got, both_hi, bad_bus, ch1_nz, rdy_bad, stray, unstable, en;
        logic [1:0]  st0;
        logic [31:0] d0;

        // Reference model: outcome of one command from the command-level rules.
        e_st = 2'd0; e_d = 32'd0; e_we = 0; e_oe = 0; e_starts = 0;
        case (op)
            2'd0, 2'd1: begin
                if (lat >= 1 && lat <= MEM_TO) begin
                    if (op == 2'd0) begin
                        e_we = lat;
                        model_mem[addr] = wd;
                    end else begin
                        e_oe = lat;
                        e_d  = {24'd0, model_mem[addr]};
                    end
                end else begin
                    e_st = 2'd1;
                    if (op == 2'd0) e_we = MEM_TO; else e_oe = MEM_TO;
                end
            end
            2'd2: begin
                e_starts = 1;
                if (lat >= 0 && lat + 1 <= RUN_TO) e_d = 32'(lat + 1);
                else begin
                    e_st = 2'd1;
                    e_d  = 32'(RUN_TO);
                end
            end
            default: e_st = 2'd2;
        endcase

        cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        check({tag, "_busy"}, cmd_ready, 1'b0);

        we_cnt = 0; oe_cnt = 0; starts = 0; age = 0; cyc = 0;
        running = 0; got = 0; both_hi = 0; bad_bus = 0; ch1_nz = 0; rdy_bad = 0; stray = 0;
        while (cyc < 300) begin
            if (rsp_valid) begin
                got = 1;
                break;
            end
            en = S_we_ram[0] | S_oe_ram[0];
            if (S_we_ram[0] && S_oe_ram[0]) both_hi = 1;
            if (S_oe_ram[1] || S_we_ram[1] || |S_addr_ram[13:7] || |S_Wdata_ram[15:8] ||
                |S_data_ram_size[7:4]) ch1_nz = 1;
            if (cmd_ready) rdy_bad = 1;
            if (S_we_ram[0]) we_cnt++;
            if (S_oe_ram[0]) oe_cnt++;
            if (en && (S_addr_ram[6:0] !== addr || S_data_ram_size[3:0] !== 4'd8 ||
                       (S_we_ram[0] && S_Wdata_ram[7:0] !== wd))) bad_bus = 1;
            if (op >= 2'd2 && (en || |S_addr_ram || |S_Wdata_ram || |S_data_ram_size)) stray = 1;
            Sout_Rdata_ram = {8'($urandom), slave_mem[S_addr_ram[6:0]]};
            Sout_DataRdy   = {1'($urandom), (en && lat > 0 && (we_cnt + oe_cnt) == lat)};
            if (S_we_ram[0] && Sout_DataRdy[0]) slave_mem[S_addr_ram[6:0]] = S_Wdata_ram[7:0];
            if (start_port) begin
                starts++;
                running = 1;
                age = 0;
            end else if (running) age++;
            done_port = running && lat >= 0 && age == lat;
            @(posedge clock); #1;
            cyc++;
        end
        Sout_DataRdy = {1'($urandom), 1'b0};
        done_port    = 1'b0;

        check({tag, "_rsp_seen"}, got, 1'b1);
        check({tag, "_status"}, rsp_status, e_st);
        check({tag, "_data"}, rsp_data, e_d);
        check({tag, "_we_cycles"}, we_cnt, e_we);
        check({tag, "_oe_cycles"}, oe_cnt, e_oe);
        check({tag, "_starts"}, starts, e_starts);
        check({tag, "_bus_rules"}, {both_hi, bad_bus, ch1_nz, rdy_bad, stray}, 5'd0);

        st0 = rsp_status; d0 = rsp_data; unstable = 0;
        repeat (hold) begin
            @(posedge clock); #1;
            if (!rsp_valid || rsp_status !== st0 || rsp_data !== d0 || cmd_ready) unstable = 1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, unstable, 1'b0);

        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check({tag, "_release"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        logic [7:0] v;
        int r, lat;
        logic [1:0] op;

        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 7'd0; cmd_wdata = 8'd0;
        rsp_ready = 1'b0; done_port = 1'b0; Sout_Rdata_ram = 16'd0; Sout_DataRdy = 2'b00;
        for (int i = 0; i < 128; i++) begin
            v = 8'($urandom);
            model_mem[i] = v;
            slave_mem[i] = v;
        end

        // Reset held with a pending command.
        cmd_valid = 1'b1; cmd_addr = 7'h05; cmd_wdata = 8'hA7;
        repeat (3) begin
            @(posedge clock); #1;
            check("rst_ready", cmd_ready, 1'b0);
            check("rst_outputs", |all_outs, 1'b0);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        check("rel_ready", cmd_ready, 1'b1);
        check("rel_no_accept", |{S_we_ram, S_oe_ram, start_port, rsp_valid}, 1'b0);
        cmd_valid = 1'b0;

        run_cmd(2'd0, 7'h05, 8'hA7, 2, 0, "wr");
        run_cmd(2'd1, 7'h05, 8'h00, 2, 0, "rd");
        run_cmd(2'd2, 7'h00, 8'h00, 10, 0, "run");
        run_cmd(2'd2, 7'h00, 8'h00, -1, 0, "run_timeout");
        run_cmd(2'd1, 7'h09, 8'h00, 0, 0, "rd_timeout");
        run_cmd(2'd3, 7'h12, 8'h34, 0, 0, "illegal");
        run_cmd(2'd0, 7'h03, 8'h5A, 3, 5, "rsp_hold");
        run_cmd(2'd2, 7'h00, 8'h00, 0, 0, "run_done_at_start");
        run_cmd(2'd2, 7'h00, 8'h00, 49, 0, "run_done_at_limit");
        run_cmd(2'd0, 7'h7F, 8'hC3, 16, 0, "wr_last_cycle");
        run_cmd(2'd1, 7'h7F, 8'h00, 1, 0, "rd_fast");

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            if (op == 2'd2) lat = $urandom_range(0, 20);
            else if ($urandom_range(0, 9) == 0) lat = ($urandom_range(0, 1) == 0) ? 0 : 17;
            else lat = $urandom_range(1, 16);
            run_cmd(op, 7'($urandom_range(0, 15)), 8'($urandom), lat, $urandom_range(0, 3), "rnd");
        end

        // Reset while a run is in progress abandons it silently.
        cmd_op = 2'd2; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("midrun_active", {start_port, rsp_valid, cmd_ready}, 3'b000);
        reset = 1'b0;
        @(posedge clock); #1;
        check("midrun_rst_outputs", |all_outs, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrun_idle_ready", cmd_ready, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check("midrun_no_rsp", {rsp_valid, start_port}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
